// File: rtl/sys_arr_pkg.sv
// Shared state encoding, defaults and load-port select codes for the array operand feeder.
package sys_arr_pkg;

   typedef enum logic [1:0] {IDLE, CLR, FEED, DONE} state_t;

   localparam int DW_DEFAULT = 8;
   localparam int N_DEFAULT  = 4;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // Feed window: N operands plus the diagonal stagger when the array registers forwarding.
   function automatic int feed_len(input int n, input int skew);
      return n + skew * (2 * n - 2);
   endfunction

endpackage

// File: rtl/sys_arr_feeder_if.sv
// Operand load port (valid/ready write of one A or B element per accepted cycle).
interface sys_arr_feeder_if import sys_arr_pkg::*; #(
   parameter int N  = N_DEFAULT,
   parameter int DW = DW_DEFAULT
);
   localparam int AW = $clog2(N);

   logic          wr_valid;
   logic          wr_ready;
   logic          wr_sel;
   logic [2*AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   modport master (output wr_valid, wr_sel, wr_addr, wr_data, input wr_ready);
   modport slave  (input wr_valid, wr_sel, wr_addr, wr_data, output wr_ready);

endinterface

// File: rtl/sys_arr_op_buf.sv
// NxN operand register file: one write port, N parallel read ports (one per lane).
module sys_arr_op_buf import sys_arr_pkg::*; #(
   parameter int N         = N_DEFAULT,
   parameter int DW        = DW_DEFAULT,
   parameter bit COL_MAJOR = 1'b0,
   localparam int AW       = $clog2(N)
) (
   input  logic                  CLK,
   input  logic                  we,
   input  logic [AW-1:0]         wrow,
   input  logic [AW-1:0]         wcol,
   input  logic [DW-1:0]         wdata,
   input  logic [N-1:0][AW-1:0]  rd_idx,
   output logic [N-1:0][DW-1:0]  rd_data
);

   logic [DW-1:0] mem [N][N];

   always_ff @(posedge CLK) begin
      if (we) mem[wrow][wcol] <= wdata;
   end

   // Row-major ports serve A (lane p = row p); column-major ports serve B (lane p = column p).
   for (genvar p = 0; p < N; p++) begin : g_rd
      if (COL_MAJOR) begin : g_col
         assign rd_data[p] = mem[rd_idx[p]][p];
      end else begin : g_row
         assign rd_data[p] = mem[p][rd_idx[p]];
      end
   end

endmodule

// File: rtl/sys_arr_feeder.sv
// Operand feeder for an NxN output-stationary MAC array: clear, skewed edge stream, done pulse.
module sys_arr_feeder import sys_arr_pkg::*; #(
   parameter int N    = N_DEFAULT,
   parameter int DW   = DW_DEFAULT,
   parameter int SKEW = 0
) (
   input  logic            CLK,
   input  logic            rst,
   sys_arr_feeder_if.slave ld,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            arr_clr,
   output logic            arr_en,
   output logic [N*DW-1:0] a_edge,
   output logic [N*DW-1:0] b_edge
);

   localparam int AW = $clog2(N);
   localparam int T  = feed_len(N, SKEW);
   localparam int CW = $clog2(T + 1);

   state_t                 state;
   logic [CW-1:0]          t;
   logic                   rdy;
   logic                   we;
   logic [CW-1:0]          nt;
   int                     k;
   logic [N-1:0][AW-1:0]   lane_idx;
   logic [N-1:0]           lane_ok;
   logic [N-1:0][DW-1:0]   a_rd;
   logic [N-1:0][DW-1:0]   b_rd;
   logic [N*DW-1:0]        a_nxt;
   logic [N*DW-1:0]        b_nxt;

   assign ld.wr_ready = rdy;
   assign we          = ld.wr_valid && rdy;

   sys_arr_op_buf #(.N(N), .DW(DW), .COL_MAJOR(1'b0)) u_abuf (
      .CLK     (CLK),
      .we      (we && (ld.wr_sel == SEL_A)),
      .wrow    (ld.wr_addr[2*AW-1:AW]),
      .wcol    (ld.wr_addr[AW-1:0]),
      .wdata   (ld.wr_data),
      .rd_idx  (lane_idx),
      .rd_data (a_rd)
   );

   sys_arr_op_buf #(.N(N), .DW(DW), .COL_MAJOR(1'b1)) u_bbuf (
      .CLK     (CLK),
      .we      (we && (ld.wr_sel == SEL_B)),
      .wrow    (ld.wr_addr[2*AW-1:AW]),
      .wcol    (ld.wr_addr[AW-1:0]),
      .wdata   (ld.wr_data),
      .rd_idx  (lane_idx),
      .rd_data (b_rd)
   );

   // Edges are registered, so the buffers are read for the step being entered (CLR loads t=0).
   always_comb begin
      nt       = (state == FEED) ? t + CW'(1) : '0;
      k        = 0;
      lane_idx = '0;
      lane_ok  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         k           = int'(nt) - SKEW * int'(i);
         lane_ok[i]  = (k >= 0) && (k < N);
         lane_idx[i] = AW'(k);
      end
   end

   always_comb begin
      a_nxt = '0;
      b_nxt = '0;
      for (int unsigned i = 0; i < N; i++) begin
         a_nxt[i*DW +: DW] = lane_ok[i] ? a_rd[i] : '0;
         b_nxt[i*DW +: DW] = lane_ok[i] ? b_rd[i] : '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state   <= IDLE;
         t       <= '0;
         rdy     <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         arr_clr <= 1'b0;
         arr_en  <= 1'b0;
         a_edge  <= '0;
         b_edge  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= CLR;
                  rdy     <= 1'b0;
                  busy    <= 1'b1;
                  arr_clr <= 1'b1;
               end
            end
            CLR: begin
               state   <= FEED;
               t       <= '0;
               arr_clr <= 1'b0;
               arr_en  <= 1'b1;
               a_edge  <= a_nxt;
               b_edge  <= b_nxt;
            end
            FEED: begin
               if (t == CW'(T - 1)) begin
                  state  <= DONE;
                  arr_en <= 1'b0;
                  done   <= 1'b1;
                  a_edge <= '0;
                  b_edge <= '0;
               end else begin
                  t      <= nt;
                  a_edge <= a_nxt;
                  b_edge <= b_nxt;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
               rdy   <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sys_arr_feeder.sv
// Bench for sys_arr_feeder: SKEW=0 and SKEW=1 instances share stimulus; per-cycle scoreboard plus PE-array model.
module tb_sys_arr_feeder;
   import sys_arr_pkg::*;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int AW  = $clog2(N);
   localparam int W   = N * DW;
   localparam int CWD = 2 * DW;

   typedef struct packed {
      logic         busy;
      logic         done;
      logic         clr;
      logic         en;
      logic         ready;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } rec_t;

   logic CLK = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic wr_valid = 1'b0;
   logic wr_sel = 1'b0;
   logic [2*AW-1:0] wr_addr = '0;
   logic [DW-1:0]   wr_data = '0;

   logic         busy_o [2];
   logic         done_o [2];
   logic         clr_o  [2];
   logic         en_o   [2];
   logic         rdy_o  [2];
   logic [W-1:0] a_e    [2];
   logic [W-1:0] b_e    [2];

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   always #5 CLK = ~CLK;

   sys_arr_feeder_if #(.N(N), .DW(DW)) if0 ();
   sys_arr_feeder_if #(.N(N), .DW(DW)) if1 ();

   assign if0.wr_valid = wr_valid;
   assign if0.wr_sel   = wr_sel;
   assign if0.wr_addr  = wr_addr;
   assign if0.wr_data  = wr_data;
   assign if1.wr_valid = wr_valid;
   assign if1.wr_sel   = wr_sel;
   assign if1.wr_addr  = wr_addr;
   assign if1.wr_data  = wr_data;
   assign rdy_o[0]     = if0.wr_ready;
   assign rdy_o[1]     = if1.wr_ready;

   sys_arr_feeder #(.N(N), .DW(DW), .SKEW(0)) u_dut0 (
      .CLK(CLK), .rst(rst), .ld(if0), .start(start),
      .busy(busy_o[0]), .done(done_o[0]), .arr_clr(clr_o[0]), .arr_en(en_o[0]),
      .a_edge(a_e[0]), .b_edge(b_e[0])
   );

   sys_arr_feeder #(.N(N), .DW(DW), .SKEW(1)) u_dut1 (
      .CLK(CLK), .rst(rst), .ld(if1), .start(start),
      .busy(busy_o[1]), .done(done_o[1]), .arr_clr(clr_o[1]), .arr_en(en_o[1]),
      .a_edge(a_e[1]), .b_edge(b_e[1])
   );

   // Reference state, one copy per instance (index = SKEW)
   logic [DW-1:0]  ma    [2][N][N];
   logic [DW-1:0]  mb    [2][N][N];
   logic [CWD-1:0] cacc  [2][N][N];
   logic [CWD-1:0] exp_c [2][N][N];
   logic [DW-1:0]  ap    [2][N][N];
   logic [DW-1:0]  bp    [2][N][N];
   logic [DW-1:0]  ain   [N][N];
   logic [DW-1:0]  bin   [N][N];
   rec_t           expq  [2][$];
   rec_t           exp_cur [2];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic rec_t idle_rec();
      rec_t r;
      r       = '0;
      r.ready = 1'b1;
      return r;
   endfunction

   task automatic push_run(input int d);
      int tl;
      int k;
      rec_t r;
      logic [CWD-1:0] acc;
      tl = N + d * (2 * N - 2);
      r = '0; r.busy = 1'b1; r.clr = 1'b1;
      expq[d].push_back(r);
      for (int t = 0; t < tl; t++) begin
         r = '0; r.busy = 1'b1; r.en = 1'b1;
         for (int i = 0; i < N; i++) begin
            k = t - d * i;
            if (k >= 0 && k < N) begin
               r.a[i*DW +: DW] = ma[d][i][k];
               r.b[i*DW +: DW] = mb[d][k][i];
            end
         end
         expq[d].push_back(r);
      end
      r = '0; r.busy = 1'b1; r.done = 1'b1;
      expq[d].push_back(r);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            acc = '0;
            for (int kk = 0; kk < N; kk++)
               acc = acc + CWD'(ma[d][i][kk]) * CWD'(mb[d][kk][j]);
            exp_c[d][i][j] = acc;
         end
   endtask

   // Behavioural PE grid driven by the DUT edges, plus the expected-output scoreboard.
   always @(posedge CLK) begin
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               if (d == 0 || j == 0) ain[i][j] = a_e[d][i*DW +: DW];
               else                  ain[i][j] = ap[d][i][j-1];
               if (d == 0 || i == 0) bin[i][j] = b_e[d][j*DW +: DW];
               else                  bin[i][j] = bp[d][i-1][j];
            end
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               if (clr_o[d])     cacc[d][i][j] = '0;
               else if (en_o[d]) cacc[d][i][j] = cacc[d][i][j] + CWD'(ain[i][j]) * CWD'(bin[i][j]);
               ap[d][i][j] = ain[i][j];
               bp[d][i][j] = bin[i][j];
            end
         if (rst) begin
            expq[d].delete();
            exp_cur[d] = idle_rec();
         end else begin
            if (!exp_cur[d].busy) begin
               if (wr_valid) begin
                  if (wr_sel == SEL_A) ma[d][wr_addr[2*AW-1:AW]][wr_addr[AW-1:0]] = wr_data;
                  else                 mb[d][wr_addr[2*AW-1:AW]][wr_addr[AW-1:0]] = wr_data;
               end
               if (start) push_run(d);
            end
            exp_cur[d] = (expq[d].size() != 0) ? expq[d].pop_front() : idle_rec();
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_on) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d busy", d),     64'(busy_o[d]), 64'(exp_cur[d].busy));
            chk($sformatf("d%0d done", d),     64'(done_o[d]), 64'(exp_cur[d].done));
            chk($sformatf("d%0d arr_clr", d),  64'(clr_o[d]),  64'(exp_cur[d].clr));
            chk($sformatf("d%0d arr_en", d),   64'(en_o[d]),   64'(exp_cur[d].en));
            chk($sformatf("d%0d wr_ready", d), 64'(rdy_o[d]),  64'(exp_cur[d].ready));
            chk($sformatf("d%0d a_edge", d),   64'(a_e[d]),    64'(exp_cur[d].a));
            chk($sformatf("d%0d b_edge", d),   64'(b_e[d]),    64'(exp_cur[d].b));
            if (exp_cur[d].done)
               for (int i = 0; i < N; i++)
                  for (int j = 0; j < N; j++)
                     chk($sformatf("d%0d C[%0d][%0d]", d, i, j),
                         64'(cacc[d][i][j]), 64'(exp_c[d][i][j]));
         end
      end
   end

   task automatic wr(input logic sel, input int r, input int c, input logic [DW-1:0] v);
      wr_valid = 1'b1;
      wr_sel   = sel;
      wr_addr  = {AW'(r), AW'(c)};
      wr_data  = v;
      @(posedge CLK); #1;
      wr_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int c;
      c = 0;
      while ((busy_o[0] || busy_o[1]) && c < 200) begin
         @(posedge CLK); #1;
         c++;
      end
      if (busy_o[0] || busy_o[1])
         chk({tag, " idle timeout"}, 64'(busy_o[0] | busy_o[1]), 64'(0));
      @(posedge CLK); #1;
   endtask

   task automatic wait_en(input string tag);
      int c;
      c = 0;
      while (!en_o[0] && c < 50) begin
         @(posedge CLK); #1;
         c++;
      end
      if (!en_o[0]) chk({tag, " arr_en timeout"}, 64'(en_o[0]), 64'(1));
   endtask

   initial begin
      rst = 1'b1;
      @(posedge CLK);
      chk_on = 1'b1;
      @(posedge CLK);
      @(posedge CLK); #1;
      rst = 1'b0;
      @(posedge CLK); #1;

      // identity A, B[k][j] = 4k+j+1
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            wr(SEL_A, r, c, (r == c) ? 8'd1 : 8'd0);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            wr(SEL_B, r, c, DW'(4 * r + c + 1));
      pulse_start();
      wait_idle("identity");

      // saturated operands
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            wr(SEL_A, r, c, 8'hFF);
            wr(SEL_B, r, c, 8'hFF);
         end
      pulse_start();
      wait_idle("all255");

      // load port and start ignored while running
      pulse_start();
      wait_en("protect");
      wr_valid = 1'b1; wr_sel = SEL_A; wr_addr = '0; wr_data = 8'h5A; start = 1'b1;
      @(posedge CLK); #1;
      wr_valid = 1'b0; start = 1'b0;
      wait_idle("protect");
      pulse_start();
      wait_idle("protect rerun");

      // reset at FEED t=2, then a clean run on the retained buffers
      pulse_start();
      wait_en("midrst");
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      rst = 1'b1;
      @(posedge CLK); #1;
      rst = 1'b0;
      wait_idle("midrst");
      pulse_start();
      wait_idle("midrst rerun");

      // write and start in the same IDLE cycle
      wr_valid = 1'b1; wr_sel = SEL_A; wr_addr = '0; wr_data = 8'd7; start = 1'b1;
      @(posedge CLK); #1;
      wr_valid = 1'b0; start = 1'b0;
      wait_idle("wr+start");

      // random operands
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            wr(SEL_A, r, c, DW'($urandom_range(0, 255)));
            wr(SEL_B, r, c, DW'($urandom_range(0, 255)));
         end
      pulse_start();
      wait_idle("random");

      // start held high: back-to-back runs at the earliest restart point
      start = 1'b1;
      repeat (40) begin
         @(posedge CLK); #1;
      end
      start = 1'b0;
      wait_idle("held start");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sys_arr_feeder.md
Name: sys_arr_feeder

Overview:
Operand feeder that drives the left and top edges of an NxN output-stationary multiply-accumulate array.
- Stores matrix A (NxN, row-major) and matrix B (NxN) written over a valid/ready load port.
- On start, clears the array accumulators, then streams A row elements into the row edges and B column elements into the column edges, with the per-lane skew the array topology needs.
- Asserts the array enable for exactly the valid window, then pulses done.
- Sits between the operand buffer/host interface and the PE grid; it is the transmit side of the PE a/b operand interface.

Parameters:
- N, 4, array dimension; power of two, at least 2.
- DW, 8, operand width in bits.
- SKEW, 0, lane stagger. 0 means the array forwards operands combinationally, so there is no stagger. 1 means the array registers operand forwarding, so lane i is delayed i cycles.
- AW, $clog2(N), derived index width; must not be overridden.

Ports:
- CLK  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock CLK
- wr_valid  in  1  load request
- wr_ready  out  1  load accept; high only in IDLE
- wr_sel  in  1  0 = write A, 1 = write B
- wr_addr  in  2*AW  {row, col} of target element; for B this is {k, j}
- wr_data  in  DW  element value
- start  in  1  begin a feed run; sampled in IDLE only
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a run
- arr_clr  out  1  accumulator clear to the array
- arr_en  out  1  accumulate enable to the array
- a_edge  out  N*DW  lane i holds the operand for array row i
- b_edge  out  N*DW  lane j holds the operand for array column j

Behaviour:
- Outputs are Moore: decoded from registered state, counter and buffers only. There is no combinational path from any input to any output.
- FSM states: IDLE, CLR, FEED, DONE.
  - IDLE: go to CLR when start=1.
  - CLR: lasts 1 cycle, then go to FEED with t=0.
  - FEED: t counts 0..T-1, where T = N + SKEW*(2N-2). Go to DONE after t=T-1.
  - DONE: lasts 1 cycle, then go to IDLE.
- Per-state outputs:
  - CLR: arr_clr=1, arr_en=0, edges 0.
  - FEED: arr_en=1, arr_clr=0.
  - DONE: done=1, arr_en=0, edges 0.
- Timing for start sampled at edge 0:
  - cycle 1 is CLR;
  - cycles 2..T+1 are FEED;
  - cycle T+2 is DONE;
  - the earliest restart is start sampled in cycle T+3.
- FEED lane data at step t:
  - a_edge[i] = A[i][t - SKEW*i];
  - b_edge[j] = B[t - SKEW*j][j];
  - when the computed index is outside 0..N-1, the lane drives 0.
- Load handshake: a write is accepted when wr_valid && wr_ready, and is committed at that clock edge. Write and start in the same IDLE cycle are both accepted, and the written value is used by that run.
- Load port outside IDLE: wr_ready=0, wr_valid is ignored, and buffers are unchanged.
- start in any state other than IDLE is ignored, with no queueing.
- Reset values: state IDLE, t=0, wr_ready=1, busy=0, done=0, arr_clr=0, arr_en=0, a_edge=0, b_edge=0.
- Buffer contents are not reset; they hold their values through rst.
- Reset mid-run: rst sampled high in any state gives IDLE in the next cycle. arr_en drops and done is not pulsed; the partial accumulation is discarded by the next run's CLR.
- Arithmetic: edges are raw DW-bit values with no sign handling. Counter width is $clog2(T+1).

Decomposition:
- Package sys_arr_pkg holds:
  - the state enum type (IDLE, CLR, FEED, DONE);
  - localparam DW_DEFAULT=8 and N_DEFAULT=4;
  - the wr_sel encodings SEL_A=0 and SEL_B=1.
- One natural sub-module, sys_arr_op_buf: an NxN DW-bit register file with one write port and N parallel read ports, one per lane index. It is instantiated once for A and once for B.

Test Plan:
- Reset: hold rst 3 cycles, then release. Required: wr_ready=1, busy=0, done=0, arr_en=0, arr_clr=0, a_edge=0, b_edge=0.
- Identity run, N=4, SKEW=0: load A=identity and B[k][j]=4k+j+1, then pulse start. Required:
  - arr_clr in cycle 1;
  - arr_en in cycles 2–5;
  - in cycle 2+t, a_edge lane t=1 and the other lanes 0;
  - done in cycle 6;
  - a behavioural PE array yields C==B.
- Skewed run, N=4, SKEW=1: load all A=B=255. Required:
  - arr_en for 10 cycles;
  - a_edge[3] is 0 at t=0..2 and 255 at t=3..6;
  - each array C element equals 4*65025 mod 2^16 = 63492.
- Protection: during FEED, drive wr_valid=1 (addr 0, data 0x5A) and start=1. Required: wr_ready=0, the run length is unchanged, there is no second run, and A[0][0] is unchanged on the next run.
- Reset mid-run: assert rst for 1 cycle at FEED t=2. Required: IDLE in the next cycle, arr_en=0, no done. A subsequent start gives a correct full run, and buffers still hold the prior loads.
- Same-cycle write+start: in IDLE, write A[0][0]=7 together with start, with SKEW=0. Required: a_edge[0]=7 at t=0 of that run.
